// File: rtl/mem_cmd_scheduler_pkg.sv
// Shared types for the memory command scheduler.
// Command and read-tag layouts plus the FSM state encoding.
package mem_cmd_scheduler_pkg;

   localparam int client_w = 3;

   typedef struct packed {
      logic        read_not_write;
      logic [31:0] address;
      logic [31:0] length;
   } mem_command_t;

   typedef struct packed {
      logic [client_w-1:0] client;
      logic [31:0]         length;
   } read_tag_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      WDATA = 2'd2
   } sched_state_t;

endpackage

// File: rtl/mem_cmd_scheduler_if.sv
// Client-side and controller-side handshake bundle.
// master: scheduler view; slave: clients + controller view.
interface mem_cmd_scheduler_if #(
   parameter int num_clients = 2,
   parameter int mem_width   = 32
);
   import mem_cmd_scheduler_pkg::*;

   logic [num_clients-1:0] cli_cmd_valid;
   logic [num_clients-1:0] cli_cmd_ready;
   mem_command_t           cli_cmd_data [num_clients];
   logic [num_clients-1:0] cli_wr_valid;
   logic [num_clients-1:0] cli_wr_ready;
   logic [mem_width-1:0]   cli_wr_data [num_clients];
   logic [num_clients-1:0] cli_rd_valid;
   logic [num_clients-1:0] cli_rd_ready;
   logic [mem_width-1:0]   cli_rd_data [num_clients];

   logic                   mem_cmd_valid;
   logic                   mem_cmd_ready;
   mem_command_t           mem_cmd_data;
   logic                   mem_write_valid;
   logic                   mem_write_ready;
   logic [mem_width-1:0]   mem_write_data;
   logic                   mem_read_valid;
   logic                   mem_read_ready;
   logic [mem_width-1:0]   mem_read_data;
   logic                   unexpected_read;

   modport master (
      input  cli_cmd_valid, cli_cmd_data,
      output cli_cmd_ready,
      input  cli_wr_valid, cli_wr_data,
      output cli_wr_ready,
      output cli_rd_valid, cli_rd_data,
      input  cli_rd_ready,
      output mem_cmd_valid, mem_cmd_data,
      input  mem_cmd_ready,
      output mem_write_valid, mem_write_data,
      input  mem_write_ready,
      input  mem_read_valid, mem_read_data,
      output mem_read_ready,
      output unexpected_read
   );

   modport slave (
      output cli_cmd_valid, cli_cmd_data,
      input  cli_cmd_ready,
      output cli_wr_valid, cli_wr_data,
      input  cli_wr_ready,
      input  cli_rd_valid, cli_rd_data,
      output cli_rd_ready,
      input  mem_cmd_valid, mem_cmd_data,
      output mem_cmd_ready,
      input  mem_write_valid, mem_write_data,
      output mem_write_ready,
      output mem_read_valid, mem_read_data,
      input  mem_read_ready,
      input  unexpected_read
   );

endinterface

// File: rtl/mem_cmd_scheduler_read_tag_fifo.sv
// In-order FIFO of outstanding read tags {client, length}.
// Ports: clk, reset (async low), push/push_tag, pop, head, full, empty.
module read_tag_fifo
   import mem_cmd_scheduler_pkg::*;
#(
   parameter int depth = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  read_tag_t push_tag,
   input  logic      pop,
   output read_tag_t head,
   output logic      full,
   output logic      empty
);

   localparam int aw = $clog2(depth);

   read_tag_t     mem [depth];
   logic [aw-1:0] wr_ptr;
   logic [aw-1:0] rd_ptr;
   logic [aw:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (aw+1)'(depth));
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot a full push needs
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_tag;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mem_cmd_scheduler.sv
// Round-robin scheduler sharing one memory cmd/write/read path.
// Ports: clk, reset (async low), bus (clients + controller).
module mem_cmd_scheduler
   import mem_cmd_scheduler_pkg::*;
#(
   parameter int num_clients     = 2,
   parameter int mem_width       = 32,
   parameter int max_outstanding = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_cmd_scheduler_if.master  bus
);

   localparam int lg_w = $clog2(num_clients);

   sched_state_t         state;
   sched_state_t         state_n;
   mem_command_t         cmd_q;
   logic [lg_w-1:0]      last_grant;
   logic [31:0]          wcount;
   logic [31:0]          rcount;
   logic                 grant_v;
   logic [lg_w-1:0]      grant_c;
   int                   c;
   logic [mem_width-1:0] wr_mux;
   logic                 wr_beat;
   logic                 tag_push;
   logic                 tag_pop;
   logic                 tag_full;
   logic                 tag_empty;
   read_tag_t            tag_in;
   read_tag_t            tag_head;
   logic                 rd_sel_ready;
   logic                 rd_beat;

   // first eligible client after last_grant; reads need a free tag slot
   always_comb begin
      grant_v = 1'b0;
      grant_c = '0;
      c       = 0;
      for (int k = 1; k <= num_clients; k++) begin
         c = (int'(last_grant) + k) % num_clients;
         if (!grant_v && bus.cli_cmd_valid[c] &&
             (!bus.cli_cmd_data[c].read_not_write || !tag_full)) begin
            grant_v = 1'b1;
            grant_c = lg_w'(c);
         end
      end
   end

   always_comb begin
      state_n             = state;
      bus.cli_cmd_ready   = '0;
      bus.mem_cmd_valid   = 1'b0;
      bus.mem_cmd_data    = '0;
      bus.mem_write_valid = 1'b0;
      bus.mem_write_data  = '0;
      bus.cli_wr_ready    = '0;
      wr_mux              = bus.cli_wr_data[last_grant];
      wr_beat             = 1'b0;
      tag_push            = 1'b0;
      unique case (state)
         IDLE: begin
            // reset gating keeps ready low while reset is held
            if (grant_v && reset) begin
               bus.cli_cmd_ready[grant_c] = 1'b1;
               if (bus.cli_cmd_data[grant_c].length != '0)
                  state_n = CMD;
            end
         end
         CMD: begin
            bus.mem_cmd_valid = 1'b1;
            bus.mem_cmd_data  = cmd_q;
            if (bus.mem_cmd_ready) begin
               if (cmd_q.read_not_write) begin
                  tag_push = 1'b1;
                  state_n  = IDLE;
               end else begin
                  state_n = WDATA;
               end
            end
         end
         WDATA: begin
            bus.mem_write_valid          = bus.cli_wr_valid[last_grant];
            bus.mem_write_data           = wr_mux;
            bus.cli_wr_ready[last_grant] = bus.mem_write_ready;
            wr_beat = bus.cli_wr_valid[last_grant] && bus.mem_write_ready;
            if (wr_beat && wcount == 32'd1)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cmd_q      <= '0;
         last_grant <= lg_w'(num_clients - 1);
         wcount     <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && grant_v) begin
            cmd_q      <= bus.cli_cmd_data[grant_c];
            last_grant <= grant_c;
         end
         if (state == CMD && bus.mem_cmd_ready && !cmd_q.read_not_write)
            wcount <= cmd_q.length;
         else if (wr_beat)
            wcount <= wcount - 32'd1;
      end
   end

   assign tag_in = '{client: client_w'(last_grant), length: cmd_q.length};

   read_tag_fifo #(.depth(max_outstanding)) u_tags (
      .clk      (clk),
      .reset    (reset),
      .push     (tag_push),
      .push_tag (tag_in),
      .pop      (tag_pop),
      .head     (tag_head),
      .full     (tag_full),
      .empty    (tag_empty)
   );

   // read data follows the head tag; other clients see zeros
   always_comb begin
      rd_sel_ready = 1'b0;
      for (int i = 0; i < num_clients; i++) begin
         bus.cli_rd_valid[i] = 1'b0;
         bus.cli_rd_data[i]  = '0;
         if (!tag_empty && tag_head.client == client_w'(i)) begin
            bus.cli_rd_valid[i] = bus.mem_read_valid;
            bus.cli_rd_data[i]  = bus.mem_read_data;
            rd_sel_ready        = bus.cli_rd_ready[i];
         end
      end
      bus.mem_read_ready = rd_sel_ready;
      rd_beat = bus.mem_read_valid && rd_sel_ready;
      tag_pop = rd_beat && (rcount == tag_head.length - 32'd1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcount              <= '0;
         bus.unexpected_read <= 1'b0;
      end else begin
         if (tag_pop)      rcount <= '0;
         else if (rd_beat) rcount <= rcount + 32'd1;
         if (tag_empty && bus.mem_read_valid)
            bus.unexpected_read <= 1'b1;
      end
   end

endmodule

// File: doc/mem_cmd_scheduler.md
Name: mem_cmd_scheduler

Overview:
- Shares one DDR memory command/write/read FIFO triple between num_clients independent requesters. Requesters are the FIFO arbiter plus host DMA/debug readback engines.
- Sits in the memory clock domain, between the clients' async FIFO outputs and the memory controller.
- Grants commands round-robin, streams write bursts from the granted client, and routes returned read data to the issuing client in order, using a tag FIFO.

Parameters:
- num_clients, 2, number of requesters (2..8).
- mem_width, 32, data word width.
- max_outstanding, 4, depth of the read tag FIFO (power of 2).

Ports:
- clk  in  1  memory-domain clock.
- reset  in  1  reset, asynchronous, active-low.
- cli_cmd_valid[num_clients]  in  1  client command valid.
- cli_cmd_ready[num_clients]  out  1  client command accepted.
- cli_cmd_data[num_clients]  in  65  MemoryCommand {read_not_write, address[31:0], length[31:0]}.
- cli_wr_valid[num_clients]  in  1  client write data valid.
- cli_wr_ready[num_clients]  out  1  client write data ready.
- cli_wr_data[num_clients]  in  mem_width  client write data.
- cli_rd_valid[num_clients]  out  1  read data valid to client.
- cli_rd_ready[num_clients]  in  1  client can take read data.
- cli_rd_data[num_clients]  out  mem_width  read data to client.
- mem_cmd_valid / mem_cmd_ready / mem_cmd_data  out/in/out  1/1/65  command to controller.
- mem_write_valid / mem_write_ready / mem_write_data  out/in/out  1/1/mem_width  write data to controller.
- mem_read_valid / mem_read_ready / mem_read_data  in/out/in  1/1/mem_width  read data from controller.
- unexpected_read  out  1  sticky: read data arrived while no read was outstanding.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last_grant=num_clients-1, tag FIFO empty, all counters 0.
  - All valid/ready outputs 0, all data outputs 0, unexpected_read=0.
- Handshake: a transfer occurs on a cycle where valid&&ready. Valid is never withdrawn before acceptance.
- State IDLE:
  - Scan clients from last_grant+1 with wrap. The first client c meeting both conditions wins:
    - cli_cmd_valid[c]=1;
    - the command is a write, or the tag FIFO is not full.
  - Winner gets cli_cmd_ready[c]=1 combinationally for that cycle only. The command is registered and last_grant<=c.
  - If the winner's length==0: command consumed and discarded, stay IDLE.
  - Otherwise go to CMD.
  - A full tag FIFO skips read requesters; a lower-priority write may win instead.
- State CMD:
  - mem_cmd_valid=1 with the held command, starting the cycle after capture (1-cycle latency).
  - On a read handshake: push {client, length} to the tag FIFO, go to IDLE.
  - On a write handshake: wcount<=length, go to WDATA.
- State WDATA:
  - Combinational mux: mem_write_valid=cli_wr_valid[g], mem_write_data=cli_wr_data[g], cli_wr_ready[g]=mem_write_ready. All other clients' cli_wr_ready=0.
  - Decrement wcount per beat. On the beat with wcount==1, go to IDLE.
  - No new command is granted until the write burst completes. This keeps write data strictly in command order.
- Read return (concurrent with the FSM):
  - When the tag FIFO is non-empty with head {h, len}: cli_rd_valid[h]=mem_read_valid, cli_rd_data[h]=mem_read_data, mem_read_ready=cli_rd_ready[h].
  - rcount counts beats. Pop the head on the beat where rcount==len-1; rcount resets to 0.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - When the tag FIFO is empty: mem_read_ready=0. If mem_read_valid=1 in that case, set unexpected_read (cleared only by reset).
  - Non-head clients: cli_rd_valid=0, cli_rd_data=0.
- Widths:
  - wcount and rcount are 32 bits; length is taken unmodified from the command.
  - last_grant is $clog2(num_clients) bits with explicit wrap at num_clients-1.

Decomposition:
- Shared package structures.sv holds:
  - MemoryCommand typedef (65 bits).
  - ReadTag typedef {client index, length[31:0]}.
  - Scheduler state localparams IDLE=0, CMD=1, WDATA=2.
- Sub-module read_tag_fifo: synchronous ReadTag FIFO, depth max_outstanding, with full/empty outputs and simultaneous push/pop support.

Test Plan:
- Clients 0 and 1 each hold a read (addr 0x100, len 4) continuously -> grants alternate 0,1,0,1; mem_cmd_valid rises 1 cycle after each cli_cmd_ready.
- Client 1 write, len 3, data A,B,C; client 0 posts a read mid-burst -> mem_write carries A,B,C; client 0's cmd_ready stays 0 until after C; then client 0's read issues.
- Reads of len 2 (client 0) then len 3 (client 1) issued; controller returns 5 words D0..D4 -> client 0 gets D0,D1; client 1 gets D2,D3,D4; tag FIFO empty afterwards.
- max_outstanding=4: five reads of len 1 with no read data returned -> fifth read not granted; a pending write from the other client still issues; returning one word grants the fifth read.
- Command with length 0 -> cli_cmd_ready pulses, no mem_cmd_valid, state stays IDLE; mem_read_valid=1 with no reads outstanding -> unexpected_read=1, mem_read_ready=0.
- Reset asserted low in WDATA after 1 of 4 beats -> all outputs 0 immediately; after release, state is IDLE and the next grant goes to client 0.
